// File: rtl/tx_record_sequencer.sv
// tx_record_sequencer
//   Upstream feeder for the transaction-tracing scoring stage. Buffers packed
//   transaction records in a DEPTH-entry FIFO, emits a one-beat new_wallet
//   marker before the first record of each wallet, then replays records one
//   per beat on the field-level interface.
//
//   Optional build macro: TS_ORDER_CHECK_EN
//     defined   - same-wallet records whose time stamp is older than the last
//                 emitted record are discarded and counted in drop_count.
//     undefined - no ordering check; drop_count is tied to zero.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   rec_valid/rec_ready upstream record handshake
//   rec_wallet_id, rec_time_stamp, rec_in, rec_method, rec_value
//                       upstream record fields
//   out_ready           downstream accept
//   out_valid           beat valid
//   new_wallet          marker beat flag
//   time_stamp, in, method_field, value
//                       beat fields (method_field = 2'b11 on marker/idle)
//   wallet_id           current wallet
//   tx_count            records emitted for current wallet (saturating)
//   drop_count          out-of-order records dropped (saturating)
module tx_record_sequencer #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned WALLET_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rec_valid,
  output logic                rec_ready,
  input  logic [WALLET_W-1:0] rec_wallet_id,
  input  logic [30:0]         rec_time_stamp,
  input  logic                rec_in,
  input  logic [1:0]          rec_method,
  input  logic [19:0]         rec_value,
  input  logic                out_ready,
  output logic                out_valid,
  output logic                new_wallet,
  output logic [30:0]         time_stamp,
  output logic                in,
  output logic [1:0]          method_field,
  output logic [19:0]         value,
  output logic [WALLET_W-1:0] wallet_id,
  output logic [15:0]         tx_count,
  output logic [7:0]          drop_count
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [WALLET_W-1:0] wallet;
    logic [30:0]         ts;
    logic                dir;
    logic [1:0]          method;
    logic [19:0]         value;
  } rec_t;

  typedef enum logic [1:0] {IDLE, MARK, DATA} state_t;

  rec_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  rec_t          head;
  rec_t          wr_rec;

  state_t        state;
  logic          have_wallet;

  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic          slot_free;
  logic          marker_needed;
  logic          drop;

  assign rec_ready  = (count < FULL) && !rst;
  assign push       = rec_valid && rec_ready;
  assign fifo_empty = (count == '0);
  assign head       = mem[rd_ptr];
  assign slot_free  = !out_valid || out_ready;
  assign wr_rec     = '{wallet: rec_wallet_id, ts: rec_time_stamp, dir: rec_in,
                        method: rec_method, value: rec_value};

  // After a marker the head always matches wallet_id; the state test makes
  // the marker -> record handoff explicit rather than relying on that.
  assign marker_needed = !fifo_empty && (state != MARK) &&
                         (!have_wallet || head.wallet != wallet_id);
  // Markers never pop; every other non-empty decision (data or drop) does.
  assign pop = slot_free && !fifo_empty && !marker_needed;

  // ---------------------------------------------------------------- FIFO
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_rec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ------------------------------------------------- time stamp ordering
`ifdef TS_ORDER_CHECK_EN
  logic [30:0] last_ts;

  // Only same-wallet records not directly following a marker are checked,
  // so a marker is always followed by its record.
  assign drop = (state != MARK) && (head.ts < last_ts);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_ts    <= '0;
      drop_count <= '0;
    end else if (pop) begin
      if (drop) begin
        if (drop_count != '1) drop_count <= drop_count + 1'b1;
      end else begin
        last_ts <= head.ts;
      end
    end
  end
`else
  assign drop       = 1'b0;
  assign drop_count = '0;
`endif

  // ----------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      have_wallet  <= 1'b0;
      out_valid    <= 1'b0;
      new_wallet   <= 1'b0;
      time_stamp   <= '0;
      in           <= 1'b0;
      method_field <= 2'b11;
      value        <= '0;
      wallet_id    <= '0;
      tx_count     <= '0;
    end else if (slot_free) begin
      if (fifo_empty || (pop && drop)) begin
        state        <= IDLE;
        out_valid    <= 1'b0;
        new_wallet   <= 1'b0;
        method_field <= 2'b11;
        in           <= 1'b0;
        value        <= '0;
      end else if (marker_needed) begin
        state        <= MARK;
        out_valid    <= 1'b1;
        new_wallet   <= 1'b1;
        time_stamp   <= head.ts;
        method_field <= 2'b11;
        in           <= 1'b0;
        value        <= '0;
        wallet_id    <= head.wallet;
        have_wallet  <= 1'b1;
        tx_count     <= '0;
      end else begin
        state        <= DATA;
        out_valid    <= 1'b1;
        new_wallet   <= 1'b0;
        time_stamp   <= head.ts;
        in           <= head.dir;
        method_field <= head.method;
        value        <= head.value;
        if (tx_count != '1) tx_count <= tx_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tx_record_sequencer.sv
module tb_tx_record_sequencer;

  localparam int DEPTH = 8;
`ifdef TS_ORDER_CHECK_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] wallet;
    logic [30:0] ts;
    logic        dir;
    logic [1:0]  method;
    logic [19:0] value;
  } rec_t;

  typedef struct packed {
    logic        nw;
    logic [30:0] ts;
    logic        dir;
    logic [1:0]  method;
    logic [19:0] value;
    logic [15:0] wallet;
    logic [15:0] txc;
  } beat_t;

  typedef struct {
    bit          vld;
    rec_t        r;
    bit          e_valid;
    bit          e_nw;
    logic [1:0]  e_method;
    logic [30:0] e_ts;
    logic [19:0] e_value;
    logic [15:0] e_txc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rec_valid = 1'b0;
  logic        rec_ready;
  logic [15:0] rec_wallet_id = '0;
  logic [30:0] rec_time_stamp = '0;
  logic        rec_in = 1'b0;
  logic [1:0]  rec_method = '0;
  logic [19:0] rec_value = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic        new_wallet;
  logic [30:0] time_stamp;
  logic        out_dir;
  logic [1:0]  method_field;
  logic [19:0] value;
  logic [15:0] wallet_id;
  logic [15:0] tx_count;
  logic [7:0]  drop_count;

  tx_record_sequencer #(.DEPTH(DEPTH), .WALLET_W(16)) dut (
    .clk(clk), .rst(rst),
    .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_wallet_id(rec_wallet_id), .rec_time_stamp(rec_time_stamp),
    .rec_in(rec_in), .rec_method(rec_method), .rec_value(rec_value),
    .out_ready(out_ready), .out_valid(out_valid), .new_wallet(new_wallet),
    .time_stamp(time_stamp), .in(out_dir), .method_field(method_field),
    .value(value), .wallet_id(wallet_id), .tx_count(tx_count),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  // upstream source queue and reference model state
  rec_t  src_q[$];
  beat_t exp_q[$];
  bit          m_have = 1'b0;
  logic [15:0] m_wallet = '0;
  logic [15:0] m_cnt = '0;
  logic [30:0] m_last = '0;
  int          m_drop = 0;
  int          n_acc = 0;
  int          n_beats = 0;
  bit          hold = 1'b0;
  logic [87:0] prev_snap = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Beat stream rules: a record starts a new wallet (marker first) when no
  // wallet is current or its wallet differs; otherwise it is either dropped
  // as out of order (feature builds only) or emitted.
  task automatic model_push(input rec_t r);
    beat_t b;
    bit    fresh;
    fresh = !m_have || (r.wallet != m_wallet);
    if (fresh) begin
      b = '{nw: 1'b1, ts: r.ts, dir: 1'b0, method: 2'b11, value: '0, wallet: r.wallet, txc: '0};
      exp_q.push_back(b);
      m_have = 1'b1; m_wallet = r.wallet; m_cnt = '0;
    end
    if (!fresh && TS_EN && (r.ts < m_last)) begin
      if (m_drop < 255) m_drop++;
    end else begin
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      m_last = r.ts;
      b = '{nw: 1'b0, ts: r.ts, dir: r.dir, method: r.method, value: r.value, wallet: r.wallet, txc: m_cnt};
      exp_q.push_back(b);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_have = 1'b0; m_wallet = '0; m_cnt = '0; m_last = '0; m_drop = 0;
  endtask

  function automatic beat_t cur_beat();
    return '{nw: new_wallet, ts: time_stamp, dir: out_dir, method: method_field,
             value: value, wallet: wallet_id, txc: tx_count};
  endfunction

  // One cycle: drive at negedge, sample 1 ns later (well before posedge).
  task automatic step(input bit rdy, input bit do_rst);
    logic [87:0] snap;
    @(negedge clk);
    rst = do_rst;
    out_ready = rdy;
    if (src_q.size() > 0) begin
      rec_valid = 1'b1;
      {rec_wallet_id, rec_time_stamp, rec_in, rec_method, rec_value} = src_q[0];
    end else begin
      rec_valid = 1'b0;
    end
    #1;
    snap = {out_valid, cur_beat()};
    if (do_rst) begin
      model_reset();
      hold = 1'b0;
    end else begin
      if (hold) chk("hold_stable", snap, prev_snap);
      if (out_valid && out_ready) begin
        n_beats++;
        if (exp_q.size() == 0) begin
          checks++; errs++;
          $display("FAIL unexpected_beat: got %h expected none", cur_beat());
        end else begin
          chk("beat", cur_beat(), exp_q.pop_front());
        end
      end
      if (rec_valid && rec_ready) begin
        model_push(src_q.pop_front());
        n_acc++;
      end
      hold = out_valid && !out_ready;
      prev_snap = snap;
    end
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (src_q.size() == 0 && exp_q.size() == 0) break;
      step(1'b1, 1'b0);
    end
    chk("drain_done", {src_q.size(), exp_q.size()}, '0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    chk("drop_count", drop_count, m_drop);
  endtask

  function automatic rec_t mk(input int w, input int ts, input int v);
    rec_t r;
    r.wallet = 16'(w); r.ts = 31'(ts); r.dir = v[0]; r.method = 2'(v % 3); r.value = 20'(v);
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[6];
    int   b0, a0;
    rec_t r1, r2, r3;

    // ---------------- reset state
    step(1'b0, 1'b1);
    chk("ready_in_reset", rec_ready, 1'b0);
    step(1'b0, 1'b0);
    chk("reset_outputs", {out_valid, cur_beat(), drop_count, rec_ready},
        {1'b0, 1'b0, 31'd0, 1'b0, 2'b11, 20'd0, 16'd0, 16'd0, 8'd0, 1'b1});

    // ---------------- table: 3 records wallet 1, ts 10/20/30, out_ready=1
    r1 = '{wallet: 16'h1, ts: 31'd10, dir: 1'b1, method: 2'b00, value: 20'd5};
    r2 = '{wallet: 16'h1, ts: 31'd20, dir: 1'b0, method: 2'b01, value: 20'd6};
    r3 = '{wallet: 16'h1, ts: 31'd30, dir: 1'b1, method: 2'b10, value: 20'd7};
    vt[0] = '{1'b1, r1, 1'b0, 1'b0, 2'b11, 31'd0,  20'd0, 16'd0};
    vt[1] = '{1'b1, r2, 1'b1, 1'b1, 2'b11, 31'd10, 20'd0, 16'd0};
    vt[2] = '{1'b1, r3, 1'b1, 1'b0, 2'b00, 31'd10, 20'd5, 16'd1};
    vt[3] = '{1'b0, r3, 1'b1, 1'b0, 2'b01, 31'd20, 20'd6, 16'd2};
    vt[4] = '{1'b0, r3, 1'b1, 1'b0, 2'b10, 31'd30, 20'd7, 16'd3};
    vt[5] = '{1'b0, r3, 1'b0, 1'b0, 2'b11, 31'd0,  20'd0, 16'd3};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      rec_valid = vt[i].vld;
      {rec_wallet_id, rec_time_stamp, rec_in, rec_method, rec_value} = vt[i].r;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), {out_valid, new_wallet, method_field, value, tx_count},
          {vt[i].e_valid, vt[i].e_nw, vt[i].e_method, vt[i].e_value, vt[i].e_txc});
      if (vt[i].e_valid) chk($sformatf("vec%0d_ts", i), time_stamp, vt[i].e_ts);
    end
    step(1'b0, 1'b1);

    // ---------------- wallet A, A, B, A
    src_q.push_back(mk(16'hA, 1, 1)); src_q.push_back(mk(16'hA, 2, 2));
    src_q.push_back(mk(16'hB, 3, 3)); src_q.push_back(mk(16'hA, 4, 4));
    b0 = n_beats;
    drain(100);
    chk("aaba_beats", n_beats - b0, 7);

    // ---------------- DEPTH+2 records with out_ready=0
    step(1'b0, 1'b1);
    for (int i = 0; i < DEPTH + 2; i++) src_q.push_back(mk(5, 100 + i, i));
    a0 = n_acc;
    for (int i = 0; i < 14; i++) step(1'b0, 1'b0);
    chk("full_accepts", n_acc - a0, DEPTH);
    chk("full_ready", rec_ready, 1'b0);
    chk("frozen_marker", {out_valid, new_wallet, time_stamp}, {1'b1, 1'b1, 31'd100});
    b0 = n_beats;
    drain(100);
    chk("full_drain_beats", n_beats - b0, DEPTH + 3);

    // ---------------- out_ready toggling during DATA
    for (int i = 0; i < 5; i++) src_q.push_back(mk(9, 200 + i, 10 + i));
    b0 = n_beats;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(i[0] ? 1'b0 : 1'b1, 1'b0);
    drain(100);
    chk("toggle_beats", n_beats - b0, 6);

    // ---------------- reset with 4 records buffered
    for (int i = 0; i < 4; i++) src_q.push_back(mk(9, 300 + i, i));
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("rst_mid_out", {out_valid, method_field, rec_ready}, {1'b0, 2'b11, 1'b1});
    src_q.push_back(mk(9, 400, 1));
    b0 = n_beats;
    drain(50);
    chk("rst_fresh_beats", n_beats - b0, 2);

    // ---------------- time stamp ordering: 50, 40, 60
    step(1'b0, 1'b1);
    src_q.push_back(mk(16'hC, 50, 1)); src_q.push_back(mk(16'hC, 40, 2));
    src_q.push_back(mk(16'hC, 60, 3));
    b0 = n_beats;
    drain(50);
    chk("ts_beats", n_beats - b0, TS_EN ? 3 : 4);
    chk("ts_drop_count", drop_count, TS_EN ? 8'd1 : 8'd0);

    // ---------------- randomized traffic
    step(1'b0, 1'b1);
    for (int i = 0; i < 600; i++) begin
      if (src_q.size() < 4 && $urandom_range(0, 99) < 70)
        src_q.push_back(mk($urandom_range(1, 3), $urandom_range(0, 40), $urandom_range(0, 1000)));
      step($urandom_range(0, 99) < 65, 1'b0);
    end
    drain(200);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
